dbg_host32: RTL and testbench
=============================

Name: dbg_host32

Overview:
- Host-side initiator for the 32-bit debug-unit UART protocol: accepts one command at a time, serialises it into bytes, and collects the target's response bytes into a 32-bit result.
- Sits between an on-chip controller (self-test sequencer, bridge from a second FPGA) and a UART byte interface; the UART module itself is instantiated outside this block.
- Flags NACK, unknown opcode and response timeout; never retries on its own.

Parameters:
- TIMEOUT_CYC, 1200000, cycles allowed between consecutive expected response bytes (100 ms at 12 MHz); minimum 2.
- OK_BYTE, 8'h01, acknowledge byte expected for 1-byte responses.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid & cmd_ready
- cmd_op  in  8  opcode
- cmd_arg  in  32  operand; only the low N bytes are sent, LSB first
- rsp_valid  out  1  one-cycle pulse at command completion
- rsp_data  out  32  assembled response, held until the next rsp_valid
- rsp_err_nack  out  1  1-byte response != OK_BYTE; valid with rsp_valid
- rsp_err_timeout  out  1  response byte missing; valid with rsp_valid
- rsp_err_badop  out  1  opcode not in table; valid with rsp_valid
- busy  out  1  ~cmd_ready
- tx_write  out  1  one-cycle pulse; UART latches tx_data
- tx_data  out  8  byte to send
- tx_finished  in  1  one-cycle pulse; UART byte done
- rx_ready  in  1  one-cycle pulse; rx_data valid
- rx_data  in  8  received byte

Behaviour:
- Reset values: cmd_ready=1, busy=0, tx_write=0, tx_data=0, rsp_valid=0, rsp_data=0, all err=0. State=IDLE. Reset mid-command drops the command and sends no further bytes.
- Length table (op: args, response bytes):
  - 01 SET_ADR: 4, 1
  - 03 GET_ADR: 0, 4
  - 04 MEM_WR: 4, 1
  - 05 MEM_RD: 0, 4
  - 20 RUN_CYC: 1, 1
  - 21 CPU_RESET: 0, 1
  - 22 FREERUN: 1, 1
  - Any other opcode is badop.
- Accept: op, arg, args and rsp_len are registered. A badop command produces rsp_valid with rsp_err_badop=1 and rsp_data=0 exactly 1 cycle after accept, with no UART traffic.
- States: IDLE -> TX_PULSE -> TX_WAIT -> (more bytes ? TX_PULSE : RX_WAIT) -> DONE -> IDLE.
- TX_PULSE:
  - tx_write=1 for exactly one cycle.
  - tx_data = op for byte 0, else arg byte k-1.
  - tx_data is held stable until tx_finished.
- TX_WAIT: waits for tx_finished. The next tx_write occurs no earlier than 1 cycle after tx_finished; there is no upper bound on the wait in TX states.
- Bytes on the wire: 1 + args total, in order op, arg[7:0], arg[15:8], and so on.
- RX_WAIT:
  - Each rx_ready stores rx_data into byte index j (0..rsp_len-1), LSB first, then j++. Unwritten bytes read 0.
  - After the last byte, go to DONE on the next cycle.
  - The timeout counter clears on entry to RX_WAIT and on each rx_ready. When it reaches TIMEOUT_CYC, go to DONE with rsp_err_timeout=1 and partial bytes kept.
- rx_ready outside RX_WAIT (including during TX): byte discarded, no error raised.
- DONE: rsp_valid=1 for one cycle. For a 1-byte response, rsp_err_nack = (byte0 != OK_BYTE) and rsp_err_timeout=0. Next cycle returns to IDLE.
- Simultaneous events:
  - rx_ready and timeout terminal count in the same cycle: the byte wins and the counter clears.
  - cmd_valid while busy: ignored; the requester holds cmd_valid.
  - cmd_valid in the same cycle DONE returns to IDLE: not accepted until cmd_ready is visible.
- Latency, 0-arg 4-byte command: accept -> TX_PULSE next cycle; rsp_valid 2 cycles after the 4th rx_ready.

Decomposition:
- Package dbg_proto_pkg holds:
  - Opcode localparams: I_ADR_PTR_SET, I_ADR_PTR_GET, I_MEM_WR, I_MEM_RD, I_CPU_RUN_CYC, I_CPU_RESET, I_CPU_FREERUN, OK.
  - A state enum.
  - Functions args_len(op) and rsp_len(op), each returning 3 bits with a valid flag.
- The package is shared with the target-side debug unit.
- No sub-module: the length lookup is combinational in the package. The UART is instantiated by the parent.

Test Plan:
- MEM_RD (op 05), UART model replies 78 56 34 12 -> exactly one byte 05 sent; rsp_valid, rsp_data=32'h12345678, no errors.
- SET_ADR arg=32'hDEADBEEF, reply 01 -> bytes 01 EF BE AD DE with each tx_write only after the prior tx_finished; rsp_data=32'h1, no err.
- MEM_WR arg=32'h0, reply 00 -> rsp_err_nack=1, rsp_data=32'h0.
- op 7F -> no tx_write ever; rsp_valid 1 cycle after accept with rsp_err_badop=1.
- MEM_RD with TIMEOUT_CYC=50, reply 2 bytes AA BB then silence -> rsp_err_timeout=1 exactly 50 cycles after the 2nd rx_ready, rsp_data=32'h0000BBAA.
- Assert reset during the 3rd byte of MEM_WR -> tx_write stays 0, cmd_ready=1 next cycle; a following GET_ADR completes normally.

Source files
------------

// File: rtl/dbg_proto_pkg.sv
// Debug-unit UART protocol definitions shared by host and target sides.
// Opcodes, host FSM states and per-opcode byte-count lookup.
package dbg_proto_pkg;

   localparam logic [7:0] I_ADR_PTR_SET = 8'h01;
   localparam logic [7:0] I_ADR_PTR_GET = 8'h03;
   localparam logic [7:0] I_MEM_WR      = 8'h04;
   localparam logic [7:0] I_MEM_RD      = 8'h05;
   localparam logic [7:0] I_CPU_RUN_CYC = 8'h20;
   localparam logic [7:0] I_CPU_RESET   = 8'h21;
   localparam logic [7:0] I_CPU_FREERUN = 8'h22;
   localparam logic [7:0] OK            = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_PULSE,
      S_TX_WAIT,
      S_RX_WAIT,
      S_DONE
   } state_t;

   typedef struct packed {
      logic       ok;
      logic [2:0] n;
   } len_t;

   function automatic len_t args_len(input logic [7:0] op);
      len_t r;
      r.ok = 1'b1;
      r.n  = 3'd0;
      case (op)
         I_ADR_PTR_SET, I_MEM_WR:              r.n = 3'd4;
         I_ADR_PTR_GET, I_MEM_RD, I_CPU_RESET: r.n = 3'd0;
         I_CPU_RUN_CYC, I_CPU_FREERUN:         r.n = 3'd1;
         default:                              r.ok = 1'b0;
      endcase
      return r;
   endfunction

   function automatic len_t rsp_len(input logic [7:0] op);
      len_t r;
      r.ok = 1'b1;
      r.n  = 3'd1;
      case (op)
         I_ADR_PTR_GET, I_MEM_RD: r.n = 3'd4;
         I_ADR_PTR_SET, I_MEM_WR, I_CPU_RUN_CYC,
         I_CPU_RESET, I_CPU_FREERUN: r.n = 3'd1;
         default: begin
            r.ok = 1'b0;
            r.n  = 3'd0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dbg_host32.sv
// Host-side initiator for the debug-unit UART protocol: sends one command
// as op + LSB-first args, then gathers the LSB-first response bytes.
module dbg_host32
   import dbg_proto_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1200000,
   parameter logic [7:0]  OK_BYTE     = OK
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err_nack,
   output logic        rsp_err_timeout,
   output logic        rsp_err_badop,
   output logic        busy,
   output logic        tx_write,
   output logic [7:0]  tx_data,
   input  logic        tx_finished,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data
);

   state_t      state, nxt;
   logic [31:0] arg_q, buf_q, cnt_q;
   logic [2:0]  nargs_q, rlen_q, idx_q, rx_j;
   len_t        al, rl;
   logic        accept, last_tx, rx_full, tmo;

   assign al      = args_len(cmd_op);
   assign rl      = rsp_len(cmd_op);
   assign accept  = cmd_valid && (state == S_IDLE);
   assign last_tx = (idx_q == nargs_q);
   assign rx_full = (rx_j == rlen_q);
   // An arriving byte always beats the terminal count.
   assign tmo     = (cnt_q >= TIMEOUT_CYC - 1) && !rx_ready;

   always_comb begin
      nxt       = state;
      cmd_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      tx_write  = (state == S_TX_PULSE);
      rsp_valid = (state == S_DONE);
      unique case (state)
         S_IDLE:
            if (accept)
               nxt = (al.ok && rl.ok) ? S_TX_PULSE : S_DONE;
         S_TX_PULSE:
            nxt = S_TX_WAIT;
         S_TX_WAIT:
            if (tx_finished)
               nxt = last_tx ? S_RX_WAIT : S_TX_PULSE;
         S_RX_WAIT:
            if (rx_full || tmo)
               nxt = S_DONE;
         S_DONE:
            nxt = S_IDLE;
         default:
            nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         arg_q           <= '0;
         buf_q           <= '0;
         cnt_q           <= '0;
         nargs_q         <= '0;
         rlen_q          <= '0;
         idx_q           <= '0;
         rx_j            <= '0;
         tx_data         <= '0;
         rsp_data        <= '0;
         rsp_err_nack    <= 1'b0;
         rsp_err_timeout <= 1'b0;
         rsp_err_badop   <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            arg_q   <= cmd_arg;
            nargs_q <= al.n;
            rlen_q  <= rl.n;
            idx_q   <= '0;
            rx_j    <= '0;
            buf_q   <= '0;
            if (al.ok && rl.ok)
               tx_data <= cmd_op;
         end
         if (state == S_TX_WAIT && tx_finished && !last_tx) begin
            idx_q   <= idx_q + 3'd1;
            tx_data <= arg_q[{idx_q[1:0], 3'b000} +: 8];
         end
         // cnt_q counts cycles since RX entry or the latest byte.
         if ((state == S_TX_WAIT && nxt == S_RX_WAIT) ||
             (state == S_RX_WAIT && rx_ready))
            cnt_q <= 32'd1;
         else if (state == S_RX_WAIT)
            cnt_q <= cnt_q + 32'd1;
         if (state == S_RX_WAIT && rx_ready && !rx_full) begin
            buf_q[{rx_j[1:0], 3'b000} +: 8] <= rx_data;
            rx_j <= rx_j + 3'd1;
         end
         if (nxt == S_DONE && state != S_DONE) begin
            rsp_data        <= (state == S_RX_WAIT) ? buf_q : '0;
            rsp_err_badop   <= (state == S_IDLE);
            rsp_err_timeout <= (state == S_RX_WAIT) && !rx_full;
            rsp_err_nack    <= (state == S_RX_WAIT) && rx_full &&
                               (rlen_q == 3'd1) &&
                               (buf_q[7:0] != OK_BYTE);
         end
      end
   end

endmodule

// File: tb/tb_dbg_host32.sv
// Randomised self-checking bench for dbg_host32 with a UART byte model
// and a table-driven protocol reference.
module tb_dbg_host32;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_op = '0;
   logic [31:0] cmd_arg = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err_nack, rsp_err_timeout, rsp_err_badop;
   logic        busy, tx_write;
   logic [7:0]  tx_data;
   logic        tx_finished = 1'b0;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data = '0;

   int asserts = 0;
   int fails = 0;

   logic [7:0] sent_q[$];
   logic [7:0] cur_byte = '0;
   int fin_cnt = 0;
   int overlap = 0;
   int unstable = 0;

   always #5 clk = ~clk;

   dbg_host32 #(.TIMEOUT_CYC(TMO), .OK_BYTE(8'h01)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err_nack(rsp_err_nack),
      .rsp_err_timeout(rsp_err_timeout),
      .rsp_err_badop(rsp_err_badop),
      .busy(busy), .tx_write(tx_write), .tx_data(tx_data),
      .tx_finished(tx_finished),
      .rx_ready(rx_ready), .rx_data(rx_data)
   );

   // UART transmitter model: latches a byte, reports done 2..6 cycles later.
   always @(negedge clk) begin
      if (reset) begin
         fin_cnt = 0;
         tx_finished = 1'b0;
      end else begin
         tx_finished = 1'b0;
         if (fin_cnt > 0) begin
            if (tx_data !== cur_byte) unstable++;
            fin_cnt--;
            if (fin_cnt == 0) tx_finished = 1'b1;
         end
         if (tx_write === 1'b1) begin
            if (fin_cnt != 0 || tx_finished) overlap++;
            sent_q.push_back(tx_data);
            cur_byte = tx_data;
            fin_cnt = $urandom_range(2, 6);
         end
      end
   end

   function automatic int m_args(input logic [7:0] op);
      case (op)
         8'h01, 8'h04:        return 4;
         8'h03, 8'h05, 8'h21: return 0;
         8'h20, 8'h22:        return 1;
         default:             return -1;
      endcase
   endfunction

   function automatic int m_rsp(input logic [7:0] op);
      case (op)
         8'h03, 8'h05:                      return 4;
         8'h01, 8'h04, 8'h20, 8'h21, 8'h22: return 1;
         default:                           return -1;
      endcase
   endfunction

   task automatic issue(input logic [7:0] op, input logic [31:0] arg,
                        output bit ok);
      int k = 0;
      while (cmd_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      ok = (cmd_ready === 1'b1);
      cmd_op = op;
      cmd_arg = arg;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op = 8'($urandom);
      cmd_arg = $urandom;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tx(input int n, output bit ok);
      int k = 0;
      while (!(sent_q.size() >= n && fin_cnt == 0 && !tx_finished) &&
             k < 500) begin
         @(negedge clk);
         k++;
      end
      ok = (k < 500);
      @(negedge clk);
   endtask

   task automatic wait_rsp(input int budget, output int k);
      k = 0;
      while (rsp_valid !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(3);
      asserts++;
      if ({cmd_ready, busy, tx_write, rsp_valid, rsp_err_nack,
           rsp_err_timeout, rsp_err_badop} !== 7'b1000000) begin
         fails++;
         $display("FAIL reset_flags: got %b want 1000000",
                  {cmd_ready, busy, tx_write, rsp_valid, rsp_err_nack,
                   rsp_err_timeout, rsp_err_badop});
      end
      reset = 1'b0;
      @(negedge clk);
      asserts++;
      if (tx_data !== 8'h00 || rsp_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: tx_data %h rsp_data %h want 0",
                  tx_data, rsp_data);
      end
   endtask

   task automatic test_mem_rd;
      bit ok;
      int k;
      logic [7:0] rep[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      sent_q.delete();
      issue(8'h05, $urandom, ok);
      asserts++;
      if (!ok || tx_write !== 1'b1 || tx_data !== 8'h05) begin
         fails++;
         $display("FAIL rd_first_pulse: tx_write %b tx_data %h want 1 05",
                  tx_write, tx_data);
      end
      wait_tx(1, ok);
      for (int i = 0; i < 4; i++) begin
         send_rx(rep[i]);
         if (i < 3) idle($urandom_range(0, 3));
      end
      wait_rsp(10, k);
      asserts++;
      if (k != 1) begin
         fails++;
         $display("FAIL rd_latency: %0d cycles want 1 after last byte", k);
      end
      asserts++;
      if (rsp_data !== 32'h12345678 ||
          {rsp_err_nack, rsp_err_timeout, rsp_err_badop} !== 3'b000) begin
         fails++;
         $display("FAIL rd_data: got %h err %b want 12345678 000", rsp_data,
                  {rsp_err_nack, rsp_err_timeout, rsp_err_badop});
      end
      asserts++;
      if (sent_q.size() != 1 || sent_q[0] !== 8'h05) begin
         fails++;
         $display("FAIL rd_bytes: %0d bytes sent want one 05", sent_q.size());
      end
      @(negedge clk);
      asserts++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
          rsp_data !== 32'h12345678) begin
         fails++;
         $display("FAIL rd_after: rsp_valid %b cmd_ready %b data %h",
                  rsp_valid, cmd_ready, rsp_data);
      end
   endtask

   task automatic test_set_adr;
      bit ok;
      int k;
      int bad = 0;
      logic [7:0] exp[5] = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      sent_q.delete();
      overlap = 0;
      unstable = 0;
      issue(8'h01, 32'hDEADBEEF, ok);
      wait_tx(5, ok);
      send_rx(8'h01);
      wait_rsp(10, k);
      if (sent_q.size() != 5) bad++;
      else for (int i = 0; i < 5; i++) if (sent_q[i] !== exp[i]) bad++;
      asserts++;
      if (bad != 0 || !ok) begin
         fails++;
         $display("FAIL set_bytes: %0d sent, %0d wrong, want 01 EF BE AD DE",
                  sent_q.size(), bad);
      end
      asserts++;
      if (overlap != 0 || unstable != 0) begin
         fails++;
         $display("FAIL set_handshake: overlap %0d unstable %0d want 0 0",
                  overlap, unstable);
      end
      asserts++;
      if (k != 1 || rsp_data !== 32'h1 ||
          {rsp_err_nack, rsp_err_timeout, rsp_err_badop} !== 3'b000) begin
         fails++;
         $display("FAIL set_rsp: k %0d data %h err %b want 1 00000001 000",
                  k, rsp_data,
                  {rsp_err_nack, rsp_err_timeout, rsp_err_badop});
      end
   endtask

   task automatic test_nack;
      bit ok;
      int k;
      sent_q.delete();
      issue(8'h04, 32'h0, ok);
      wait_tx(5, ok);
      send_rx(8'h00);
      wait_rsp(10, k);
      asserts++;
      if (k != 1 || rsp_data !== 32'h0 ||
          {rsp_err_nack, rsp_err_timeout, rsp_err_badop} !== 3'b100) begin
         fails++;
         $display("FAIL nack: k %0d data %h err %b want 1 0 100",
                  k, rsp_data,
                  {rsp_err_nack, rsp_err_timeout, rsp_err_badop});
      end
   endtask

   task automatic test_badop;
      bit ok;
      int k;
      sent_q.delete();
      issue(8'h7F, $urandom, ok);
      wait_rsp(5, k);
      asserts++;
      if (k != 0 || rsp_data !== 32'h0 ||
          {rsp_err_nack, rsp_err_timeout, rsp_err_badop} !== 3'b001) begin
         fails++;
         $display("FAIL badop: k %0d data %h err %b want 0 0 001",
                  k, rsp_data,
                  {rsp_err_nack, rsp_err_timeout, rsp_err_badop});
      end
      idle(10);
      asserts++;
      if (sent_q.size() != 0) begin
         fails++;
         $display("FAIL badop_tx: %0d bytes sent want 0", sent_q.size());
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int k;
      sent_q.delete();
      issue(8'h05, $urandom, ok);
      wait_tx(1, ok);
      send_rx(8'hAA);
      idle(2);
      send_rx(8'hBB);
      wait_rsp(200, k);
      asserts++;
      if (k != TMO - 1) begin
         fails++;
         $display("FAIL tmo_latency: %0d cycles want %0d", k + 1, TMO);
      end
      asserts++;
      if (rsp_data !== 32'h0000BBAA ||
          {rsp_err_nack, rsp_err_timeout, rsp_err_badop} !== 3'b010) begin
         fails++;
         $display("FAIL tmo_rsp: data %h err %b want 0000bbaa 010", rsp_data,
                  {rsp_err_nack, rsp_err_timeout, rsp_err_badop});
      end
   endtask

   task automatic test_tmo_edge;
      bit ok;
      int k;
      int early = 0;
      sent_q.delete();
      issue(8'h03, $urandom, ok);
      wait_tx(1, ok);
      send_rx(8'h11);
      for (int i = 0; i < TMO - 2; i++) begin
         if (rsp_valid === 1'b1) early++;
         @(negedge clk);
      end
      send_rx(8'h22);
      send_rx(8'h33);
      send_rx(8'h44);
      wait_rsp(10, k);
      asserts++;
      if (early != 0 || k != 1 || rsp_data !== 32'h44332211 ||
          rsp_err_timeout !== 1'b0) begin
         fails++;
         $display("FAIL tmo_edge: early %0d k %0d data %h tmo %b",
                  early, k, rsp_data, rsp_err_timeout);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int k = 0;
      int n;
      logic [7:0] b[4];
      logic [31:0] exp = '0;
      sent_q.delete();
      issue(8'h04, $urandom, ok);
      while (sent_q.size() < 3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      reset = 1'b1;
      @(negedge clk);
      asserts++;
      if (k >= 200 || tx_write !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset: tx_write %b cmd_ready %b want 0 1",
                  tx_write, cmd_ready);
      end
      reset = 1'b0;
      n = sent_q.size();
      idle(20);
      asserts++;
      if (sent_q.size() != n) begin
         fails++;
         $display("FAIL mid_reset_quiet: %0d bytes after reset want 0",
                  sent_q.size() - n);
      end
      sent_q.delete();
      issue(8'h03, $urandom, ok);
      wait_tx(1, ok);
      for (int i = 0; i < 4; i++) begin
         b[i] = 8'($urandom);
         exp = exp | (32'(b[i]) << (8 * i));
         send_rx(b[i]);
      end
      wait_rsp(10, k);
      asserts++;
      if (k != 1 || rsp_data !== exp || sent_q.size() != 1 ||
          {rsp_err_nack, rsp_err_timeout, rsp_err_badop} !== 3'b000) begin
         fails++;
         $display("FAIL post_reset_get: data %h want %h sent %0d",
                  rsp_data, exp, sent_q.size());
      end
   endtask

   task automatic test_random;
      logic [7:0] tbl[7] = '{8'h01, 8'h03, 8'h04, 8'h05,
                             8'h20, 8'h21, 8'h22};
      for (int it = 0; it < 16; it++) begin
         bit ok;
         int k, na, nr, bad;
         logic [7:0] op, b0;
         logic [31:0] arg, exp;
         int r = $urandom_range(0, 8);
         op = (r < 7) ? tbl[r] : 8'($urandom);
         arg = $urandom;
         na = m_args(op);
         nr = m_rsp(op);
         sent_q.delete();
         overlap = 0;
         issue(op, arg, ok);
         if (na < 0) begin
            wait_rsp(5, k);
            asserts++;
            if (k != 0 || rsp_err_badop !== 1'b1 || rsp_data !== 32'h0) begin
               fails++;
               $display("FAIL rnd_badop op %h: k %0d badop %b data %h",
                        op, k, rsp_err_badop, rsp_data);
            end
            continue;
         end
         if ($urandom_range(0, 1) == 1) send_rx(8'hFF);
         wait_tx(1 + na, ok);
         bad = (sent_q.size() != 1 + na) ? 1 : 0;
         if (bad == 0) begin
            if (sent_q[0] !== op) bad++;
            for (int i = 0; i < na; i++)
               if (sent_q[i + 1] !== 8'(arg >> (8 * i))) bad++;
         end
         asserts++;
         if (bad != 0 || overlap != 0) begin
            fails++;
            $display("FAIL rnd_tx op %h: %0d sent want %0d overlap %0d",
                     op, sent_q.size(), 1 + na, overlap);
         end
         exp = '0;
         b0 = '0;
         for (int i = 0; i < nr; i++) begin
            logic [7:0] b;
            b = (nr == 1 && $urandom_range(0, 1) == 1) ? 8'h01
                                                      : 8'($urandom);
            if (i == 0) b0 = b;
            exp = exp | (32'(b) << (8 * i));
            send_rx(b);
         end
         wait_rsp(10, k);
         asserts++;
         if (k != 1 || rsp_data !== exp || busy !== 1'b1 ||
             cmd_ready !== 1'b0 || rsp_err_timeout !== 1'b0 ||
             rsp_err_badop !== 1'b0 ||
             rsp_err_nack !== (nr == 1 && b0 != 8'h01)) begin
            fails++;
            $display("FAIL rnd_rsp op %h: k %0d data %h want %h nack %b",
                     op, k, rsp_data, exp, rsp_err_nack);
         end
         idle($urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_mem_rd();
      test_badop();
      test_set_adr();
      test_nack();
      test_timeout();
      test_tmo_edge();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end

endmodule
